// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive path: FSM states, framing constants
// and the CRC-32 byte step used by the FCS engine.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREA = 3'd1,
        ST_HEAD = 3'd2,
        ST_DATA = 3'd3,
        ST_DROP = 3'd4
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam int          HDR_LEN       = 14;
    localparam int          FCS_LEN       = 4;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

    localparam logic [2:0]  PRE_MAX  = 3'd7;
    localparam logic [3:0]  DST_LAST = 4'd5;
    localparam logic [3:0]  SRC_LAST = 4'd11;
    localparam logic [3:0]  HDR_LAST = 4'(HDR_LEN - 1);
    // Post-header bytes needed before the holdback line has a payload byte to release.
    localparam logic [2:0]  DATA_MIN = 3'(FCS_LEN + 1);

    // Ethernet bit order: each byte enters LSB first into an MSB-shifting register.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_fcs.sv
// CRC-32 engine shared with the transmit side; one byte per enabled cycle,
// Reset reseeds the register for a new frame.
module eth_fcs
    import eth_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  Data_in,
    input  logic        Enable,
    output logic [31:0] Crc
);

    // CRC register update.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Crc <= 32'hFFFF_FFFF;
        end else if (Enable) begin
            Crc <= crc32_byte(Crc, Data_in);
        end
    end

endmodule

// File: rtl/rx_eth.sv
// Ethernet receive deframer: strips preamble/SFD, parses and filters the header,
// forwards payload as AXI-Stream with the FCS held back and checked.
module rx_eth
    import eth_pkg::*;
#(
    parameter bit PROMISC = 1'b0
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic [47:0] local_mac,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic [47:0] rx_dst_mac,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_eth_type,
    output logic        fcs_ok,
    output logic        rx_err,
    output logic        rx_drop
);

    logic [7:0]  byte_r;
    logic        valid_r;
    rx_state_e   state_r;
    logic [2:0]  pre_cnt_r;
    logic [3:0]  hdr_cnt_r;
    logic [2:0]  data_cnt_r;
    logic [47:0] dst_r;
    logic [47:0] src_r;
    logic [15:0] type_r;
    logic [31:0] hold_r;
    logic [7:0]  pend_r;
    logic        first_r;
    logic        err_pend_r;
    logic        drop_pend_r;

    logic [47:0] dst_next_s;
    logic        addr_hit_s;
    logic        crc_rst_s;
    logic        crc_en_s;
    logic [31:0] crc_s;

    eth_fcs u_fcs (
        .Clk     (s_axis_aclk),
        .Reset   (crc_rst_s),
        .Data_in (byte_r),
        .Enable  (crc_en_s),
        .Crc     (crc_s)
    );

    // Filter sees the destination including the byte currently being parsed.
    always_comb begin
        dst_next_s = {dst_r[39:0], byte_r};
        if (PROMISC) begin
            addr_hit_s = 1'b1;
        end else begin
            addr_hit_s = (dst_next_s == local_mac) || (dst_next_s == BCAST_MAC);
        end
        crc_rst_s = valid_r && (state_r == ST_PREA) && (byte_r == SFD_BYTE);
        if (valid_r && ((state_r == ST_HEAD) || (state_r == ST_DATA))) begin
            crc_en_s = 1'b1;
        end else begin
            crc_en_s = 1'b0;
        end
    end

    // Input register stage and the extra stage that places error/drop pulses.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            byte_r  <= 8'h00;
            valid_r <= 1'b0;
            rx_err  <= 1'b0;
            rx_drop <= 1'b0;
        end else begin
            byte_r  <= s_axis_tdata;
            valid_r <= s_axis_tvalid;
            rx_err  <= err_pend_r;
            rx_drop <= drop_pend_r;
        end
    end

    // Deframing FSM with registered stream outputs.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_r       <= ST_IDLE;
            pre_cnt_r     <= 3'd0;
            hdr_cnt_r     <= 4'd0;
            data_cnt_r    <= 3'd0;
            dst_r         <= 48'h0;
            src_r         <= 48'h0;
            type_r        <= 16'h0;
            hold_r        <= 32'h0;
            pend_r        <= 8'h00;
            first_r       <= 1'b0;
            err_pend_r    <= 1'b0;
            drop_pend_r   <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            fcs_ok        <= 1'b0;
            rx_dst_mac    <= 48'h0;
            rx_src_mac    <= 48'h0;
            rx_eth_type   <= 16'h0;
        end else begin
            err_pend_r    <= 1'b0;
            drop_pend_r   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            fcs_ok        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_r) begin
                        if (byte_r == PREAMBLE_BYTE) begin
                            state_r   <= ST_PREA;
                            pre_cnt_r <= 3'd1;
                        end else begin
                            state_r    <= ST_DROP;
                            err_pend_r <= 1'b1;
                        end
                    end
                end
                ST_PREA: begin
                    if (!valid_r) begin
                        state_r    <= ST_IDLE;
                        err_pend_r <= 1'b1;
                    end else if (byte_r == PREAMBLE_BYTE) begin
                        if (pre_cnt_r == PRE_MAX) begin
                            state_r    <= ST_DROP;
                            err_pend_r <= 1'b1;
                        end else begin
                            pre_cnt_r <= pre_cnt_r + 3'd1;
                        end
                    end else if (byte_r == SFD_BYTE) begin
                        state_r   <= ST_HEAD;
                        hdr_cnt_r <= 4'd0;
                    end else begin
                        state_r    <= ST_DROP;
                        err_pend_r <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    if (!valid_r) begin
                        state_r    <= ST_IDLE;
                        err_pend_r <= 1'b1;
                    end else begin
                        if (hdr_cnt_r <= DST_LAST) begin
                            dst_r <= dst_next_s;
                        end else if (hdr_cnt_r <= SRC_LAST) begin
                            src_r <= {src_r[39:0], byte_r};
                        end else begin
                            type_r <= {type_r[7:0], byte_r};
                        end
                        hdr_cnt_r <= hdr_cnt_r + 4'd1;
                        if ((hdr_cnt_r == DST_LAST) && !addr_hit_s) begin
                            state_r     <= ST_DROP;
                            drop_pend_r <= 1'b1;
                        end else if (hdr_cnt_r == HDR_LAST) begin
                            state_r    <= ST_DATA;
                            data_cnt_r <= 3'd0;
                            first_r    <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // A pending byte exists only once DATA_MIN bytes have passed the holdback line.
                    if (valid_r) begin
                        hold_r <= {hold_r[23:0], byte_r};
                        pend_r <= hold_r[31:24];
                        if (data_cnt_r == DATA_MIN) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= pend_r;
                            m_axis_tuser  <= first_r;
                            first_r       <= 1'b0;
                            if (first_r) begin
                                rx_dst_mac  <= dst_r;
                                rx_src_mac  <= src_r;
                                rx_eth_type <= type_r;
                            end
                        end else begin
                            data_cnt_r <= data_cnt_r + 3'd1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        if (data_cnt_r == DATA_MIN) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= pend_r;
                            m_axis_tuser  <= first_r;
                            m_axis_tlast  <= 1'b1;
                            fcs_ok        <= (crc_s == CRC_RESIDUE);
                            first_r       <= 1'b0;
                            if (first_r) begin
                                rx_dst_mac  <= dst_r;
                                rx_src_mac  <= src_r;
                                rx_eth_type <= type_r;
                            end
                        end else begin
                            err_pend_r <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (!valid_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_eth.sv
// Scoreboard bench for rx_eth: frames are built with an independent reflected CRC-32,
// expected payload beats are queued at drive time and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_rx_eth;

    localparam logic [47:0] LOCAL = 48'h0200_0000_0001;
    localparam logic [47:0] SRC   = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] local_mac;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tuser, m_tlast;
    logic [47:0] rx_dst_mac, rx_src_mac;
    logic [15:0] rx_eth_type;
    logic        fcs_ok, rx_err, rx_drop;

    typedef struct { logic [7:0] data; bit pay; bit first; bit last; } tx_byte_t;
    typedef struct { logic [7:0] data; bit user; bit last; bit fcs; int cyc; } exp_beat_t;

    tx_byte_t  tx_q[$];
    exp_beat_t exp_q[$];
    int        err_q[$];
    int        drop_q[$];
    int        samp_q[$];
    exp_beat_t mon_e;
    int        cyc = 0;
    int        n_tests = 0;
    int        n_fail = 0;
    bit        fcs_good;
    bit        accepting;
    int        last_fall;

    rx_eth #(.PROMISC(1'b0)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .local_mac      (local_mac),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tuser   (m_tuser),
        .m_axis_tlast   (m_tlast),
        .rx_dst_mac     (rx_dst_mac),
        .rx_src_mac     (rx_src_mac),
        .rx_eth_type    (rx_eth_type),
        .fcs_ok         (fcs_ok),
        .rx_err         (rx_err),
        .rx_drop        (rx_drop)
    );

    always #5 clk = ~clk;

    // Count active edges; a byte driven at a negedge is sampled at edge cyc+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each beat, logs pulse times.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", m_tvalid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("tdata", m_tdata, mon_e.data);
                    check_eq("tuser", m_tuser, mon_e.user);
                    check_eq("tlast", m_tlast, mon_e.last);
                    check_eq("fcs_ok", fcs_ok, mon_e.fcs);
                    check_eq("latency", cyc, mon_e.cyc);
                end
            end
            if (rx_err)  err_q.push_back(cyc);
            if (rx_drop) drop_q.push_back(cyc);
        end
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic tx_byte_t mk(input logic [7:0] d, input bit p, input bit f, input bit l);
        tx_byte_t t;
        t.data = d; t.pay = p; t.first = f; t.last = l;
        return t;
    endfunction

    task automatic build(input int npre, input logic [47:0] dst, input logic [15:0] typ,
                         input int plen, input logic [7:0] p0, input bit corrupt, input bit accept);
        logic [31:0] crc;
        logic [7:0]  hdr[14];
        logic [7:0]  b;
        tx_q.delete();
        for (int i = 0; i < npre; i++) tx_q.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        tx_q.push_back(mk(8'hD5, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++) hdr[i] = dst[47-8*i -: 8];
        for (int i = 0; i < 6; i++) hdr[6+i] = SRC[47-8*i -: 8];
        hdr[12] = typ[15:8];
        hdr[13] = typ[7:0];
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 14; i++) begin
            crc = crc_step(crc, hdr[i]);
            tx_q.push_back(mk(hdr[i], 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < plen; i++) begin
            b = p0 + 8'(i);
            crc = crc_step(crc, b);
            tx_q.push_back(mk(b, accept, i == 0, i == plen - 1));
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) begin
            b = crc[8*i +: 8];
            if (corrupt && i == 3) b = b ^ 8'h01;
            tx_q.push_back(mk(b, 1'b0, 1'b0, 1'b0));
        end
        fcs_good = !corrupt;
    endtask

    task automatic send(input int nbytes, input int gap, input int rst_at);
        int n;
        exp_beat_t e;
        n = (nbytes < 0) ? tx_q.size() : nbytes;
        samp_q.delete();
        accepting = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_tvalid", m_tvalid, 1'b0);
                check_eq("rst_tdata", m_tdata, 8'h00);
                check_eq("rst_dst", rx_dst_mac, 48'h0);
                check_eq("rst_type", rx_eth_type, 16'h0);
                exp_q.delete();
                accepting = 1'b0;
            end
            if (rst_at >= 0 && i == rst_at + 3) rst_n = 1'b1;
            s_tdata  = tx_q[i].data;
            s_tvalid = 1'b1;
            samp_q.push_back(cyc + 1);
            if (tx_q[i].pay && accepting) begin
                e.data = tx_q[i].data;
                e.user = tx_q[i].first;
                e.last = tx_q[i].last;
                e.fcs  = tx_q[i].last && fcs_good;
                e.cyc  = cyc + 1 + 6;
                exp_q.push_back(e);
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (g == 0) last_fall = cyc + 1;
            s_tvalid = 1'b0;
            s_tdata  = 8'h00;
        end
    endtask

    task automatic settle(input string tag, input int n_err, input int n_drop);
        repeat (12) @(negedge clk);
        check_eq({tag, "_drain"}, exp_q.size(), 0);
        check_eq({tag, "_errs"}, err_q.size(), n_err);
        check_eq({tag, "_drops"}, drop_q.size(), n_drop);
    endtask

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; local_mac = LOCAL;
        repeat (3) @(negedge clk);
        check_eq("reset_flags", {m_tvalid, m_tuser, m_tlast, fcs_ok, rx_err, rx_drop}, 6'b0);
        check_eq("reset_tdata", m_tdata, 8'h00);
        check_eq("reset_hdr", {rx_dst_mac, rx_eth_type}, 64'h0);
        check_eq("reset_src", rx_src_mac, 48'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        build(7, LOCAL, 16'h0800, 46, 8'h01, 1'b0, 1'b1);
        send(-1, 1, -1);
        settle("loopback", 0, 0);
        check_eq("loop_type", rx_eth_type, 16'h0800);
        check_eq("loop_dst", rx_dst_mac, LOCAL);
        check_eq("loop_src", rx_src_mac, SRC);

        build(7, LOCAL, 16'h0800, 46, 8'h01, 1'b1, 1'b1);
        send(-1, 1, -1);
        settle("bad_fcs", 0, 0);

        build(7, 48'h0200_0000_0002, 16'h0806, 46, 8'h01, 1'b0, 1'b0);
        send(-1, 1, -1);
        settle("filter_miss", 0, 1);
        check_eq("drop_cyc", first_of(drop_q), samp_q[13] + 2);
        check_eq("miss_dst_kept", rx_dst_mac, LOCAL);
        check_eq("miss_type_kept", rx_eth_type, 16'h0800);
        drop_q.delete();

        build(7, BCAST, 16'h0800, 46, 8'h10, 1'b0, 1'b1);
        send(-1, 1, -1);
        settle("broadcast", 0, 0);
        check_eq("bcast_dst", rx_dst_mac, BCAST);

        build(7, LOCAL, 16'h0800, 46, 8'h01, 1'b0, 1'b0);
        send(7 + 1 + 10, 3, -1);
        settle("runt", 1, 0);
        check_eq("runt_cyc", first_of(err_q), last_fall + 2);
        err_q.delete();

        tx_q.delete();
        tx_q.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        tx_q.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        tx_q.push_back(mk(8'h5D, 1'b0, 1'b0, 1'b0));
        tx_q.push_back(mk(8'h12, 1'b0, 1'b0, 1'b0));
        tx_q.push_back(mk(8'h34, 1'b0, 1'b0, 1'b0));
        send(-1, 1, -1);
        settle("bad_pre", 1, 0);
        check_eq("bad_pre_cyc", first_of(err_q), samp_q[2] + 2);
        err_q.delete();

        build(9, LOCAL, 16'h0800, 46, 8'h01, 1'b0, 1'b0);
        send(-1, 1, -1);
        settle("long_pre", 1, 0);
        check_eq("long_pre_cyc", first_of(err_q), samp_q[7] + 2);
        err_q.delete();

        build(1, LOCAL, 16'h0800, 46, 8'h20, 1'b0, 1'b1);
        send(-1, 1, -1);
        build(7, LOCAL, 16'h86DD, 46, 8'h40, 1'b0, 1'b1);
        send(-1, 1, -1);
        settle("b2b", 0, 0);
        check_eq("b2b_type", rx_eth_type, 16'h86DD);

        build(7, LOCAL, 16'h0801, 1, 8'hA5, 1'b0, 1'b1);
        send(-1, 1, -1);
        settle("single", 0, 0);
        check_eq("single_type", rx_eth_type, 16'h0801);

        build(7, LOCAL, 16'h0800, 46, 8'h01, 1'b0, 1'b1);
        send(-1, 1, 32);
        settle("rst_mid", 1, 0);
        check_eq("rst_mid_err_cyc", first_of(err_q), samp_q[35] + 2);
        err_q.delete();

        build(7, LOCAL, 16'h0800, 46, 8'h30, 1'b0, 1'b1);
        send(-1, 1, -1);
        settle("after_rst", 0, 0);
        check_eq("after_rst_dst", rx_dst_mac, LOCAL);
        check_eq("after_rst_type", rx_eth_type, 16'h0800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
